// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf_pkg
// Description : Shared types for the pipeline stage buffer. It holds the
//               three-state occupancy encoding and a helper that maps a state
//               to its entry count.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_buf_pkg;

  // The encoding equals the occupancy count, so the helper below is trivial
  // in hardware.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_buf_state_e;

  function automatic logic [1:0] state_occupancy(input pipe_buf_state_e s);
    logic [1:0] n;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Valid/ready pipeline stage buffer placed between pipeline
//               stages. SKID=1 gives a two-entry skid buffer whose in_ready
//               depends only on the buffer state and flush. SKID=0 gives a
//               single register whose in_ready also follows out_ready.
//               A flush kills the held entries and the entry offered in the
//               same cycle.
// Ports       : clk       - rising-edge clock
//               rst_n     - synchronous active-low reset
//               in_valid  - upstream payload valid
//               in_ready  - buffer accepts in_data this cycle
//               in_data   - upstream payload (DATA_W bits)
//               out_valid - out_data holds a valid entry
//               out_ready - downstream accepts this cycle
//               out_data  - head entry, driven from a register
//               flush     - discard all held and incoming entries
//               occupancy - number of valid entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  pipe_buf_state_e   state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_occupancy(state_q);

  // In skid mode, ready is registered-state only. This breaks the
  // combinational out_ready->in_ready path through the pipeline. In single
  // mode, the one register can only take a new entry when the old entry
  // leaves in the same cycle.
  generate
    if (SKID) begin : g_rdy_skid
      assign in_ready = rst_n && (state_q != ST_FULL) && !flush;
    end else begin : g_rdy_single
      assign in_ready = rst_n && (!out_valid || out_ready) && !flush;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            // The new entry parks in the skid register. The head stays in
            // main so that FIFO order is kept. Single mode never gets here
            // because its in_ready needs out_ready while ONE.
            if (SKID) begin
              state_d = ST_FULL;
            end
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_d;

      always_comb begin
        skid_d = skid_q;
        if (flush || (state_q == ST_FULL && out_ready)) begin
          skid_d = BUBBLE;
        end else if (state_q == ST_ONE && in_xfer && !out_xfer) begin
          skid_d = in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          skid_q <= BUBBLE;
        end else begin
          skid_q <= skid_d;
        end
      end
    end else begin : g_no_skid
      // FULL is unreachable, so the skid source is never selected.
      assign skid_q = BUBBLE;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits (1..1024); a stage bundle is carried flattened.
REQ-002 The block SHALL have parameter SKID, default 1: 1 = two-entry skid mode, 0 = single-register mode.
REQ-003 The block SHALL have parameter BUBBLE, default all-zero DATA_W-bit value, giving the payload held when no entry is valid.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream payload is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts this cycle; low means stall.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: head payload, driven from a register.
REQ-012 The block SHALL have port flush, input, 1 bit: kill all held and incoming entries, e.g. on a taken branch or jump.
REQ-013 The block SHALL have port occupancy, output, 2 bits: the number of valid entries (0..2).

Function
REQ-014 A transfer SHALL occur on a side only in a cycle where that side's valid and ready are both 1; no transfer occurs otherwise.
REQ-015 The block SHALL use three states: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
REQ-016 In SKID=0, FULL SHALL be unreachable.
REQ-017 In EMPTY: in_valid SHALL give next state ONE with main<=in_data; otherwise the block stays in EMPTY.
REQ-018 In ONE with an input transfer and an output transfer, the block SHALL stay in ONE with main<=in_data.
REQ-019 In ONE with an input transfer and no output transfer (SKID=1 only), the next state SHALL be FULL with skid<=in_data.
REQ-020 In ONE with an output transfer and no input transfer, the next state SHALL be EMPTY with main<=BUBBLE.
REQ-021 In FULL, in_ready SHALL be 0.
REQ-022 In FULL, out_ready SHALL give next state ONE with main<=skid and skid<=BUBBLE; otherwise the block stays in FULL.
REQ-023 In SKID=1, in_ready SHALL be (state!=FULL) && !flush; it SHALL depend only on state and flush, never on out_ready.
REQ-024 In SKID=0, in_ready SHALL be (!out_valid || out_ready) && !flush.
REQ-025 out_valid SHALL be (state!=EMPTY), and out_data SHALL be the main register.
REQ-026 An input transfer SHALL appear on out_valid/out_data exactly 1 cycle later when the block was EMPTY or ONE-with-drain.
REQ-027 Ordering SHALL be strictly FIFO: the main entry leaves before the skid entry; no payload is duplicated or lost except by flush.
REQ-028 flush SHALL have priority over all transitions: next state EMPTY, main and skid <= BUBBLE, and in_data is discarded (in_ready=0 that cycle).
REQ-029 An output transfer in a flush cycle (out_valid && out_ready) SHALL count as delivered.
REQ-030 While FULL and stalled, out_data and skid SHALL hold their values indefinitely.
REQ-031 in_data SHALL be ignored whenever in_ready=0, even if in_valid=1.

Reset
REQ-032 While rst_n=0 at a rising edge, the next state SHALL be EMPTY with main and skid <= BUBBLE; after that edge occupancy=0, out_valid=0 and out_data=BUBBLE.
REQ-033 in_ready SHALL be 0 while rst_n=0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst_n rises (flush=0).
REQ-035 Reset asserted mid-operation SHALL discard all entries with the same result as REQ-032; reset SHALL take priority over flush.

Structure
REQ-036 The state encoding Pipe_Buf_State_Case (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) SHALL be defined in the shared package Pkg.
REQ-037 The block SHALL be a single module with no sub-module; the skid path SHALL be removed by generate when SKID=0.
REQ-038 Instances SHALL be used between Fetch/Decode/Execute/Memory/WriteBack, with DATA_W=$bits of the bundle.

Verification
REQ-039 Scenario: SKID=1, out_ready=1, send 0xA1,0xA2,0xA3 back-to-back -> the same values on out_data in cycles 1,2,3 after input, occupancy never 2.
REQ-040 Scenario: SKID=1, load 0xB1, drop out_ready, offer 0xB2 then 0xB3 -> FULL, in_ready=0, 0xB3 held off; raise out_ready -> 0xB1, 0xB2, 0xB3 delivered in order.
REQ-041 Scenario: SKID=1, FULL with 0xC1/0xC2, out_ready=0, flush=1 with in_valid=1 and 0xC3 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE, 0xC3 never emitted.
REQ-042 Scenario: SKID=0, hold out_ready=0 with 0xD1 held -> in_ready=0; set out_ready=1 with 0xD2 -> in_ready=1 the same cycle, 0xD2 on out_data next cycle.
REQ-043 Scenario: rst_n=0 for 1 edge while FULL -> occupancy=0, out_data=BUBBLE, in_ready=1 in the first cycle after release.
REQ-044 Scenario: random valid/ready/flush for 10k cycles against a reference queue model -> no loss, duplication or reordering of unflushed payloads.
